vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 213 +++++++++++++++++++++
 tb/tb_vga_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Captures a 1-bit-per-colour VGA stream into a frame-buffer write port,
// one write per visible pixel, and flags line-timing errors.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_TOTAL     = 800,
  parameter int CLK_PER_PIX = 2
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        vga_red,
  input  logic        vga_green,
  input  logic        vga_blue,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        cap_en,
  output logic        cap_we,
  output logic [18:0] cap_addr,
  output logic [2:0]  cap_data,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);

  // state   | meaning
  // IDLE    | capture disabled, waiting for cap_en
  // WAIT_VS | armed, waiting for a vsync falling edge
  // V_PORCH | counting hsync edges through vertical sync and back porch
  // LINE    | sampling the visible pixels of line y
  // DONE    | single end-of-frame cycle, frame_done asserted
  typedef enum logic [2:0] {IDLE, WAIT_VS, V_PORCH, LINE, DONE} state_t;

  localparam int LINE_CLKS = H_TOTAL * CLK_PER_PIX;
  localparam int LW = $clog2(LINE_CLKS + 1) + 1;
  localparam int PW = $clog2(H_START * CLK_PER_PIX + 1) + 1;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int VW = $clog2(V_START + 1) + 1;
  localparam logic [PW-1:0] PIX_FIRST = PW'(H_START * CLK_PER_PIX - 1);
  localparam logic [PW-1:0] PIX_NEXT  = PW'(CLK_PER_PIX - 1);
  localparam logic [18:0]   H_ACT_A   = 19'(H_ACTIVE);
  // {hsync, vsync, red, green, blue}: syncs idle high, colours idle low
  localparam logic [4:0]    SYNC_RST  = 5'b11000;

  logic [4:0]    sync_q1, sync_q2;
  logic          hs_d, vs_d;
  logic          hs_fe, vs_fe;
  logic [2:0]    rgb_s;
  logic [LW-1:0] lclk;
  logic          line_ok;

  state_t        state;
  logic [PW-1:0] pix_tmr;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [VW-1:0] vcnt;
  logic [18:0]   line_base;
  logic [18:0]   addr_cnt;
  logic          px_active;
  logic          h_valid;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= SYNC_RST;
      sync_q2 <= SYNC_RST;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
    end else begin
      sync_q1 <= {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue};
      sync_q2 <= sync_q1;
      hs_d    <= sync_q2[4];
      vs_d    <= sync_q2[3];
    end
  end

  assign hs_fe   = !sync_q2[4] && hs_d;
  assign vs_fe   = !sync_q2[3] && vs_d;
  assign rgb_s   = sync_q2[2:0];
  assign line_ok = (lclk == LW'(LINE_CLKS));

  // Clocks since the last hsync falling edge; saturates on a lost hsync.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)
      lclk <= '0;
    else if (hs_fe)
      lclk <= LW'(1);
    else if (lclk != '1)
      lclk <= lclk + LW'(1);
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      pix_tmr    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      vcnt       <= '0;
      line_base  <= '0;
      addr_cnt   <= '0;
      px_active  <= 1'b0;
      h_valid    <= 1'b0;
    end else begin
      cap_we     <= 1'b0;
      frame_done <= 1'b0;
      if (pix_tmr != '0)
        pix_tmr <= pix_tmr - PW'(1);

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cap_en) begin
            state    <= WAIT_VS;
            sync_err <= 1'b0;
          end
        end

        WAIT_VS: begin
          busy <= 1'b0;
          if (!cap_en) begin
            state <= IDLE;
          end else if (vs_fe) begin
            // a coincident hsync edge is line 0 and starts interval timing
            state   <= V_PORCH;
            busy    <= 1'b1;
            vcnt    <= '0;
            h_valid <= hs_fe;
          end
        end

        V_PORCH: begin
          if (vs_fe) begin
            sync_err <= 1'b1;
            vcnt     <= '0;
            h_valid  <= hs_fe;
          end else if (hs_fe) begin
            if (h_valid && !line_ok)
              sync_err <= 1'b1;
            h_valid <= 1'b1;
            if (vcnt == VW'(V_START - 1)) begin
              state     <= LINE;
              y_cnt     <= '0;
              x_cnt     <= '0;
              line_base <= '0;
              addr_cnt  <= '0;
              px_active <= 1'b1;
              pix_tmr   <= PIX_FIRST;
            end else begin
              vcnt <= vcnt + VW'(1);
            end
          end
        end

        LINE: begin
          if (vs_fe) begin
            state     <= V_PORCH;
            sync_err  <= 1'b1;
            vcnt      <= '0;
            h_valid   <= hs_fe;
            px_active <= 1'b0;
          end else if (hs_fe) begin
            // an edge while pixels remain means a short line: skip the rest
            if (!line_ok || px_active)
              sync_err <= 1'b1;
            if (y_cnt == YW'(V_ACTIVE - 1)) begin
              state      <= DONE;
              frame_done <= 1'b1;
              px_active  <= 1'b0;
            end else begin
              y_cnt     <= y_cnt + YW'(1);
              line_base <= line_base + H_ACT_A;
              addr_cnt  <= line_base + H_ACT_A;
              x_cnt     <= '0;
              px_active <= 1'b1;
              pix_tmr   <= PIX_FIRST;
            end
          end else if (px_active) begin
            if (pix_tmr == '0) begin
              cap_we   <= 1'b1;
              cap_data <= rgb_s;
              cap_addr <= addr_cnt;
              addr_cnt <= addr_cnt + 19'd1;
              pix_tmr  <= PIX_NEXT;
              if (x_cnt == XW'(H_ACTIVE - 1))
                px_active <= 1'b0;
              else
                x_cnt <= x_cnt + XW'(1);
            end
          end else if (y_cnt == YW'(V_ACTIVE - 1)) begin
            // leave one cycle after the last sample so its write stays in LINE
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= cap_en ? WAIT_VS : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced raster: pixel writes are
// predicted as the stimulus is driven and compared as the DUT emits them.
module tb_vga_capture;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int H_START  = 3;
  localparam int V_START  = 2;
  localparam int H_TOTAL  = 14;
  localparam int CPP      = 2;
  localparam int HS_W     = 2;
  localparam int FRAME_LINES = V_START + V_ACTIVE + 2;
  localparam int FRAME_PIX   = H_ACTIVE * V_ACTIVE;
  // two synchronizer stages, sample offset from T0, one-cycle write register
  localparam int LAT = 2 + H_START * CPP + 1;

  typedef struct packed {
    logic [18:0] addr;
    logic [2:0]  data;
  } sb_t;

  logic        clk_50mhz = 1'b0;
  logic        rst_n;
  logic        vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync;
  logic        cap_en;
  logic        cap_we;
  logic [18:0] cap_addr;
  logic [2:0]  cap_data;
  logic        busy, frame_done, sync_err;

  sb_t sb_q[$];
  sb_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  wr_cnt  = 0;
  int  fd_cnt  = 0;
  int  lat_cyc = 0;
  bit  lat_arm = 1'b0;
  bit  cap_live = 1'b1;
  logic fd_err = 1'b0;
  int  base_w, base_f, waited;

  vga_capture #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_START(H_START),
    .V_START(V_START), .H_TOTAL(H_TOTAL), .CLK_PER_PIX(CPP)
  ) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .cap_en(cap_en),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #10 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc++;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  // One raster frame (or its first n_lines lines); vsync low for all of line 0.
  task automatic drive_frame(input int n_lines, input bit cap, input int short_line,
                             input int short_slots, input int drop_line);
    sb_t e;
    int  y, x, slots;
    logic [2:0] pix;
    for (int l = 0; l < n_lines; l++) begin
      slots = (l == short_line) ? short_slots : H_TOTAL;
      if (l == drop_line) cap_en = 1'b0;
      y = l - V_START;
      for (int s = 0; s < slots; s++) begin
        x = s - H_START;
        for (int c = 0; c < CPP; c++) begin
          @(negedge clk_50mhz);
          if (c == 0) begin
            vga_hsync = (s >= HS_W);
            vga_vsync = (l != 0);
            if (y >= 0 && y < V_ACTIVE && x >= 0 && x < H_ACTIVE) begin
              pix = 3'(x + 2 * y);
              {vga_red, vga_green, vga_blue} = pix;
              if (cap && cap_live) begin
                e.addr = 19'(y * H_ACTIVE + x);
                e.data = pix;
                sb_q.push_back(e);
              end
            end else begin
              {vga_red, vga_green, vga_blue} = 3'($urandom_range(0, 7));
            end
            if (l == V_START && s == 0) lat_cyc = cyc;
          end
        end
      end
    end
  endtask

  always @(negedge clk_50mhz) begin
    if (cap_we) begin
      wr_cnt++;
      check_val("wr_expected", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_val("wr_addr", int'(cap_addr), int'(mon_e.addr));
        check_val("wr_data", int'(cap_data), int'(mon_e.data));
      end
      if (lat_arm && cap_addr == 19'd0) begin
        check_val("px0_latency", cyc - lat_cyc, LAT);
        lat_arm = 1'b0;
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_err = sync_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cap_en = 1'b0;
    vga_hsync = 1'b1; vga_vsync = 1'b1;
    {vga_red, vga_green, vga_blue} = 3'b111;
    wait_clks(3);
    check_val("rst_cap_we", int'(cap_we), 0);
    check_val("rst_cap_addr", int'(cap_addr), 0);
    check_val("rst_cap_data", int'(cap_data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_frame_done", int'(frame_done), 0);
    check_val("rst_sync_err", int'(sync_err), 0);
    rst_n = 1'b1;
    cap_en = 1'b1;
    wait_clks(4);

    // nominal frame, including first-pixel latency
    base_w = wr_cnt; base_f = fd_cnt; lat_arm = 1'b1;
    drive_frame(FRAME_LINES, 1'b1, -1, 0, -1);
    check_val("nom_writes", wr_cnt - base_w, FRAME_PIX);
    check_val("nom_done", fd_cnt - base_f, 1);
    check_val("nom_sync_err", int'(sync_err), 0);
    check_val("nom_busy_after", int'(busy), 0);
    check_val("nom_sb_empty", sb_q.size(), 0);
    check_val("nom_latency_seen", int'(lat_arm), 0);

    // one visible line two slots short: pixels all land, interval is wrong
    base_w = wr_cnt; base_f = fd_cnt;
    drive_frame(FRAME_LINES, 1'b1, V_START + 1, H_TOTAL - 2, -1);
    check_val("short_writes", wr_cnt - base_w, FRAME_PIX);
    check_val("short_done", fd_cnt - base_f, 1);
    check_val("short_err_at_done", int'(fd_err), 1);
    check_val("short_err_after", int'(sync_err), 1);
    cap_en = 1'b0;
    wait_clks(4);
    check_val("short_err_idle", int'(sync_err), 1);
    cap_en = 1'b1;
    wait_clks(4);
    check_val("short_err_cleared", int'(sync_err), 0);

    // line y=2 cut to 9 slots: last two pixels skipped, next line from y*H
    base_w = wr_cnt; base_f = fd_cnt;
    drive_frame(FRAME_LINES, 1'b1, V_START + 2, H_START + H_ACTIVE - 2, -1);
    check_val("early_writes", wr_cnt - base_w, FRAME_PIX - 2);
    check_val("early_done", fd_cnt - base_f, 1);
    check_val("early_sync_err", int'(sync_err), 1);
    check_val("early_sb_empty", sb_q.size(), 0);
    cap_en = 1'b0;
    wait_clks(4);
    cap_en = 1'b1;
    wait_clks(4);

    // vsync injected at visible line 2: restart, then a full frame from 0
    base_w = wr_cnt; base_f = fd_cnt;
    drive_frame(V_START + 2, 1'b1, -1, 0, -1);
    check_val("inj_no_done", fd_cnt - base_f, 0);
    drive_frame(FRAME_LINES, 1'b1, -1, 0, -1);
    check_val("inj_writes", wr_cnt - base_w, 2 * H_ACTIVE + FRAME_PIX);
    check_val("inj_done", fd_cnt - base_f, 1);
    check_val("inj_sync_err", int'(sync_err), 1);
    check_val("inj_sb_empty", sb_q.size(), 0);

    // cap_en dropped mid-frame: frame completes, the next one is ignored
    base_w = wr_cnt; base_f = fd_cnt;
    drive_frame(FRAME_LINES, 1'b1, -1, 0, V_START + 1);
    check_val("drop_writes", wr_cnt - base_w, FRAME_PIX);
    check_val("drop_done", fd_cnt - base_f, 1);
    base_w = wr_cnt;
    drive_frame(FRAME_LINES, 1'b0, -1, 0, -1);
    check_val("drop_next_writes", wr_cnt - base_w, 0);
    check_val("drop_next_done", fd_cnt - base_f, 1);
    check_val("drop_busy", int'(busy), 0);

    // reset pulse at line 1 pixel 5, then a fresh frame from address 0
    cap_en = 1'b1;
    wait_clks(4);
    base_w = wr_cnt; base_f = fd_cnt; waited = 0;
    fork
      drive_frame(FRAME_LINES, 1'b1, -1, 0, -1);
      begin
        while (wr_cnt < base_w + H_ACTIVE + 5 && waited < 1000) begin
          @(negedge clk_50mhz);
          #2;
          waited++;
        end
        check_val("rst_point_reached", int'(wr_cnt >= base_w + H_ACTIVE + 5), 1);
        rst_n = 1'b0;
        cap_live = 1'b0;
        sb_q.delete();
        #1;
        check_val("midrst_cap_we", int'(cap_we), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_addr", int'(cap_addr), 0);
        wait_clks(3);
        rst_n = 1'b1;
      end
    join
    check_val("midrst_no_done", fd_cnt - base_f, 0);
    check_val("midrst_writes", wr_cnt - base_w, H_ACTIVE + 5);
    cap_live = 1'b1;
    base_w = wr_cnt;
    drive_frame(FRAME_LINES, 1'b1, -1, 0, -1);
    check_val("postrst_writes", wr_cnt - base_w, FRAME_PIX);
    check_val("postrst_done", fd_cnt - base_f, 1);
    check_val("postrst_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
